// File: rtl/mem_wb_if.sv
// EX/MEM-to-WB bundle: control and operands into the memory stage, registered write-back results out.
// The stage itself uses the slave modport; whatever feeds it and consumes its results uses master.
interface mem_wb_if;
  logic [31:0] alu_result;
  logic [31:0] read_data2;
  logic [4:0]  regdst;
  logic        regwrite;
  logic        memwrite;
  logic        memread;
  logic        memtoreg;
  logic [5:0]  ALU_op;

  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_regwrite;
  logic [31:0] mem_data_wb;
  logic [31:0] alu_result_wb;
  logic        misaligned_wb;
  logic [7:0]  fault_count;

  modport master (
    output alu_result, read_data2, regdst, regwrite, memwrite, memread, memtoreg, ALU_op,
    input  wb_data, wb_reg, wb_regwrite, mem_data_wb, alu_result_wb, misaligned_wb, fault_count
  );

  modport slave (
    input  alu_result, read_data2, regdst, regwrite, memwrite, memread, memtoreg, ALU_op,
    output wb_data, wb_reg, wb_regwrite, mem_data_wb, alu_result_wb, misaligned_wb, fault_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB register: byte/half/word loads and stores against a
// little-endian data memory, misalignment trapping and a saturating fault counter.
module mem_wb_stage #(
  parameter int         DEPTH = 1024,
  parameter logic [5:0] OP_LW = 6'd20,
  parameter logic [5:0] OP_LH = 6'd21,
  parameter logic [5:0] OP_LB = 6'd22,
  parameter logic [5:0] OP_SW = 6'd23,
  parameter logic [5:0] OP_SH = 6'd24,
  parameter logic [5:0] OP_SB = 6'd25
) (
  input  logic     clk,
  input  logic     reset,
  mem_wb_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] word_idx;
  logic [1:0]    offset;
  logic          unused_addr_bits;

  // Bits above the word index are ignored, so addresses wrap modulo DEPTH*4.
  assign word_idx         = bus.alu_result[AW+1:2];
  assign offset           = bus.alu_result[1:0];
  assign unused_addr_bits = ^bus.alu_result[31:AW+2];

  logic load_en;
  logic store_en;
  logic acc_word;
  logic acc_half;
  logic acc_byte;
  logic misaligned;

  assign load_en  = bus.memread & ~bus.memwrite;
  assign store_en = bus.memwrite;

  always_comb begin
    acc_word = 1'b0;
    acc_half = 1'b0;
    acc_byte = 1'b0;
    if (store_en) begin
      unique case (bus.ALU_op)
        OP_SH:   acc_half = 1'b1;
        OP_SB:   acc_byte = 1'b1;
        default: acc_word = 1'b1;
      endcase
    end else if (load_en) begin
      unique case (bus.ALU_op)
        OP_LH:   acc_half = 1'b1;
        OP_LB:   acc_byte = 1'b1;
        default: acc_word = 1'b1;
      endcase
    end
  end

  assign misaligned = (acc_word & (offset != 2'b00)) | (acc_half & offset[0]);

  logic        mem_we;
  logic [3:0]  byte_en;
  logic [31:0] wdata;

  assign mem_we = store_en & ~misaligned & ~reset;

  always_comb begin
    byte_en = 4'b0000;
    wdata   = bus.read_data2;
    if (acc_half) begin
      byte_en = offset[1] ? 4'b1100 : 4'b0011;
      wdata   = {2{bus.read_data2[15:0]}};
    end else if (acc_byte) begin
      byte_en = 4'b0001 << offset;
      wdata   = {4{bus.read_data2[7:0]}};
    end else begin
      byte_en = 4'b1111;
    end
  end

  logic [31:0] rd_word;

  // One independent RAM per byte lane keeps lane writes free of read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      always_ff @(posedge clk) begin
        if (mem_we && byte_en[gi]) begin
          lane_q[word_idx] <= wdata[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_q[word_idx];
    end
  endgenerate

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;

  assign half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    byte_sel = rd_word[7:0];
    unique case (offset)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
    endcase
  end

  always_comb begin
    load_data = 32'd0;
    if (load_en && !misaligned) begin
      if (acc_half) begin
        load_data = {{16{half_sel[15]}}, half_sel};
      end else if (acc_byte) begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end else begin
        load_data = rd_word;
      end
    end
  end

  logic [4:0]  wb_reg_q;
  logic        wb_regwrite_q;
  logic        wb_regwrite_d;
  logic [31:0] mem_data_q;
  logic [31:0] alu_result_q;
  logic        misaligned_q;
  logic        memtoreg_q;
  logic [7:0]  fault_count_q;
  logic [7:0]  fault_count_d;

  assign wb_regwrite_d = bus.regwrite & ~misaligned;
  assign fault_count_d = (misaligned && fault_count_q != 8'hFF) ? fault_count_q + 8'd1
                                                               : fault_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_reg_q      <= '0;
      wb_regwrite_q <= 1'b0;
      mem_data_q    <= '0;
      alu_result_q  <= '0;
      misaligned_q  <= 1'b0;
      memtoreg_q    <= 1'b0;
      fault_count_q <= '0;
    end else begin
      wb_reg_q      <= bus.regdst;
      wb_regwrite_q <= wb_regwrite_d;
      mem_data_q    <= load_data;
      alu_result_q  <= bus.alu_result;
      misaligned_q  <= misaligned;
      memtoreg_q    <= bus.memtoreg;
      fault_count_q <= fault_count_d;
    end
  end

  assign bus.wb_data       = memtoreg_q ? mem_data_q : alu_result_q;
  assign bus.wb_reg        = wb_reg_q;
  assign bus.wb_regwrite   = wb_regwrite_q;
  assign bus.mem_data_wb   = mem_data_q;
  assign bus.alu_result_wb = alu_result_q;
  assign bus.misaligned_wb = misaligned_q;
  assign bus.fault_count   = fault_count_q;

endmodule
